// File: rtl/biquad_seq_ctrl_pkg.sv
// Shared definitions for the biquad sequencer: word format, state encoding and
// the operand-select codes understood by the coefficient/state/addend selector.
package biquad_seq_ctrl_pkg;

   localparam int N = 24;
   localparam int F = 14;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S1   = 3'd1,
      ST_S2   = 3'd2,
      ST_S3   = 3'd3,
      ST_S4   = 3'd4,
      ST_S5   = 3'd5,
      ST_UPD  = 3'd6
   } state_t;

   // Coefficient select (controlS); 110/111 are reserved
   localparam logic [2:0] SEL_ZERO = 3'b000;
   localparam logic [2:0] SEL_A1   = 3'b001;
   localparam logic [2:0] SEL_A2   = 3'b010;
   localparam logic [2:0] SEL_B0   = 3'b011;
   localparam logic [2:0] SEL_B1   = 3'b100;
   localparam logic [2:0] SEL_B2   = 3'b101;

   // State select (controlC)
   localparam logic [1:0] SEL_ST_ZERO = 2'b00;
   localparam logic [1:0] SEL_FK1     = 2'b01;
   localparam logic [1:0] SEL_FK2     = 2'b10;
   localparam logic [1:0] SEL_FK      = 2'b11;

   // Addend select (controlZ); 110/111 are reserved
   localparam logic [2:0] SEL_ADD_ZERO = 3'b000;
   localparam logic [2:0] SEL_UK       = 3'b001;
   localparam logic [2:0] SEL_YK       = 3'b010;
   localparam logic [2:0] SEL_ACUM1    = 3'b011;
   localparam logic [2:0] SEL_ACUM2    = 3'b100;
   localparam logic [2:0] SEL_ACUM3    = 3'b101;

endpackage

// File: rtl/biquad_seq_ctrl.sv
// Direct Form II biquad sequencer: five MAC steps per sample, owning the delay
// line, input sample and partial sums, and capturing the datapath result.
module biquad_seq_ctrl
   import biquad_seq_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         clear,
   input  logic [N-1:0] uk_in,
   input  logic [N-1:0] mac_sum,
   output logic [2:0]   controlS,
   output logic [1:0]   controlC,
   output logic [2:0]   controlZ,
   output logic [N-1:0] Uk,
   output logic [N-1:0] fk,
   output logic [N-1:0] fk1,
   output logic [N-1:0] fk2,
   output logic [N-1:0] acum1,
   output logic [N-1:0] acum2,
   output logic [N-1:0] acum3,
   output logic [N-1:0] yk,
   output logic         busy,
   output logic         done,
   output logic         overrun,
   output logic [2:0]   fsm_state
);

   // Handshake: start is accepted only on an edge where busy is low (IDLE);
   // done pulses for exactly one cycle when yk is new, and yk holds until the next done.
   state_t state_r, state_nx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_r <= ST_IDLE;
      else        state_r <= state_nx;
   end

   always_comb begin
      state_nx = state_r;
      unique case (state_r)
         ST_IDLE: if (start) state_nx = ST_S1;
         ST_S1:   state_nx = ST_S2;
         ST_S2:   state_nx = ST_S3;
         ST_S3:   state_nx = ST_S4;
         ST_S4:   state_nx = ST_S5;
         ST_S5:   state_nx = ST_UPD;
         ST_UPD:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
      if (clear) state_nx = ST_IDLE;
   end

   // Selects depend on state only, so mac_sum never reaches an output combinationally
   always_comb begin
      controlS = SEL_ZERO;
      controlC = SEL_ST_ZERO;
      controlZ = SEL_ADD_ZERO;
      busy     = (state_r != ST_IDLE);
      done     = (state_r == ST_UPD) && !clear;
      unique case (state_r)
         ST_S1: begin controlS = SEL_A1; controlC = SEL_FK1; controlZ = SEL_UK;       end
         ST_S2: begin controlS = SEL_A2; controlC = SEL_FK2; controlZ = SEL_ACUM1;    end
         ST_S3: begin controlS = SEL_B0; controlC = SEL_FK;  controlZ = SEL_ADD_ZERO; end
         ST_S4: begin controlS = SEL_B1; controlC = SEL_FK1; controlZ = SEL_ACUM2;    end
         ST_S5: begin controlS = SEL_B2; controlC = SEL_FK2; controlZ = SEL_ACUM3;    end
         default: ;
      endcase
   end

   assign fsm_state = state_r;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Uk <= '0; fk <= '0; fk1 <= '0; fk2 <= '0;
         acum1 <= '0; acum2 <= '0; acum3 <= '0; yk <= '0;
         overrun <= 1'b0;
      end else if (clear) begin
         Uk <= '0; fk <= '0; fk1 <= '0; fk2 <= '0;
         acum1 <= '0; acum2 <= '0; acum3 <= '0; yk <= '0;
         overrun <= 1'b0;
      end else begin
         if (busy && start) overrun <= 1'b1;
         unique case (state_r)
            ST_IDLE: if (start) Uk <= uk_in;
            ST_S1:   acum1 <= mac_sum;
            ST_S2:   fk    <= mac_sum;
            ST_S3:   acum2 <= mac_sum;
            ST_S4:   acum3 <= mac_sum;
            ST_S5:   yk    <= mac_sum;
            ST_UPD: begin
               fk2 <= fk1;
               fk1 <= fk;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/biquad_seq_ctrl.md
Name: biquad_seq_ctrl

Overview:
Sequencer and state-register bank for the fixed-point biquad IIR section (Direct Form II). It drives the three operand-select codes consumed by the coefficient/state/addend selector, owns the delay line (fk, fk1, fk2), the input sample Uk and partial sums acum1..acum3, and captures the multiply-add result returned by the datapath. It runs one 5-MAC sample computation per start strobe and presents yk with a done pulse.

Parameters:
N, `N (24), total word width, two's complement Q(N-F).F
F, `F (14), fractional bits; coefficients are Q2.14 sign-extended to N

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all registers
start  in  1  sample strobe, sampled only in IDLE
clear  in  1  synchronous state flush (delay line, partials, yk, overrun)
uk_in  in  N  input sample, captured when start accepted
mac_sum  in  N  datapath result = ((muxS*muxC)>>>F) + muxZ, combinational from current selects
controlS  out  3  coefficient select: 000 zero, 001 a1, 010 a2, 011 b0, 100 b1, 101 b2
controlC  out  2  state select: 00 zero, 01 fk1, 10 fk2, 11 fk
controlZ  out  3  addend select: 000 zero, 001 Uk, 010 yk, 011 acum1, 100 acum2, 101 acum3
Uk, fk, fk1, fk2, acum1, acum2, acum3  out  N each  register values feeding the selector
yk  out  N  filter output, held until next done
busy  out  1  high in S1..UPD
done  out  1  one-cycle pulse in UPD
overrun  out  1  sticky: start seen while busy

Behaviour:
- Reset (reset=0, async): state IDLE; all N-bit registers 0; selects 000/00/000; busy, done, overrun 0.
- States: IDLE, S1, S2, S3, S4, S5, UPD; one MAC per cycle; mac_sum captured at end of each S-state.
- IDLE: selects zero. start=1 at edge -> Uk<=uk_in, go S1.
- S1: S=001 C=01 Z=001 -> acum1<=mac_sum (Uk + a1*fk1).
- S2: S=010 C=10 Z=011 -> fk<=mac_sum (acum1 + a2*fk2).
- S3: S=011 C=11 Z=000 -> acum2<=mac_sum (b0*fk).
- S4: S=100 C=01 Z=100 -> acum3<=mac_sum (acum2 + b1*fk1).
- S5: S=101 C=10 Z=101 -> yk<=mac_sum (acum3 + b2*fk2).
- UPD: selects zero, done=1; at edge fk2<=fk1, fk1<=fk; -> IDLE.
- Latency: start accepted at edge k -> done high in cycle k+6 (the cycle after edge k+5), yk valid from that cycle; min sample period 7 cycles (start may be reasserted in the first IDLE cycle after UPD).
- Selects are pure functions of state (Moore); no combinational path from mac_sum to outputs.
- Arithmetic: no width growth inside block; mac_sum stored as-is (wrap is the datapath's policy).
- start while busy (S1..UPD): ignored, overrun<=1; sequence unaffected.
- clear: highest synchronous priority; any state -> IDLE, zero Uk, fk, fk1, fk2, acum1..3, yk, overrun; done suppressed that cycle. clear and start together: clear wins, start dropped.
- Reset asserted mid-sequence: immediate return to reset values; no done.
- Selector codes 110/111 never driven.

Decomposition:
- Shared package/constantes: N, F, state encoding localparams, select-code localparams (SEL_ZERO, SEL_A1 ... SEL_ACUM3) so selector and sequencer share one definition.
- No sub-module; FSM plus register bank in one module. Bench instantiates existing selector + behavioural multiplier/adder to close the mac_sum loop.

Test Plan:
- Reset mid-S3 -> all outputs 0, state IDLE next edge, no done pulse.
- Zero state, start with uk_in=16384 (1.0) -> select sequence 001/01/001, 010/10/011, 011/11/000, 100/01/100, 101/10/101 over cycles k+1..k+5; fk=16384; yk=1362; done at k+6; then fk1=16384, fk2=0.
- Next start with uk_in=0 -> fk=16957, yk=1409+2724=4133; after UPD fk1=16957, fk2=16384.
- Start pulsed at k+2 during busy -> overrun=1, yk and timing unchanged; clear -> overrun=0 and all state 0.
- Back-to-back: start held high continuously -> accepts every 7 cycles, done pulses 7 apart, overrun set (starts seen while busy).
- clear and start same edge in IDLE -> stays IDLE, Uk unchanged at 0, busy stays 0.
